// File: rtl/softmax_div_feeder.sv
// softmax_div_feeder: collects one vector of exponential values, sums them,
// turns the sum into a signed base-2 exponent and then replays the buffered
// values, tagged with that exponent, as a handshaked stream to the divider.
module softmax_div_feeder #(
    parameter int unsigned VEC_LEN  = 10,
    parameter int unsigned SUM_BIAS = 12
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        exp_in_tvalid,
    output logic        exp_in_tready,
    input  logic [23:0] exp_in_tdata,
    input  logic        exp_in_tlast,
    output logic        div_in_tvalid,
    input  logic        div_in_tready,
    output logic [7:0]  divisor_exponent_tdata,
    output logic [23:0] dividend_power_tdata,
    output logic        div_in_tlast
);
    localparam int unsigned AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned CW = $clog2(VEC_LEN + 1);

    typedef enum logic [1:0] {ST_LOAD, ST_CALC, ST_SEND} state_t;

    state_t        state;
    state_t        state_nxt;

    logic [23:0]   buf_mem [VEC_LEN];
    logic [CW-1:0] cnt;
    logic [CW-1:0] len;
    logic [AW-1:0] rd;
    logic [AW-1:0] rd_nxt;
    logic [31:0]   sum;
    logic [7:0]    exp_reg;
    logic [7:0]    exp_calc;
    logic [5:0]    msb;
    logic          in_hs;
    logic          out_hs;
    logic          load_done;

    assign exp_in_tready          = (state == ST_LOAD);
    assign in_hs                  = exp_in_tvalid && exp_in_tready;
    assign out_hs                 = div_in_tvalid && div_in_tready;
    assign load_done              = in_hs && (exp_in_tlast || (cnt == CW'(VEC_LEN - 1)));
    assign rd_nxt                 = rd + AW'(1);
    assign divisor_exponent_tdata = exp_reg;

    // State register
    always_ff @(posedge aclk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: load until tlast or full, one calc cycle, send until last handshake
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LOAD: if (load_done) state_nxt = ST_CALC;
            ST_CALC: state_nxt = ST_SEND;
            ST_SEND: if (out_hs && div_in_tlast) state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Index of the highest set bit of the running sum
    always_comb begin
        msb = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (sum[i]) msb = 6'(i);
        end
    end

    assign exp_calc = (sum == '0) ? 8'hF0 : (8'(msb) - 8'(SUM_BIAS));

    // Element buffer; intentionally not reset so a discarded vector leaves stale data
    always_ff @(posedge aclk) begin
        if (in_hs) buf_mem[cnt[AW-1:0]] <= exp_in_tdata;
    end

    // Accumulation, exponent latch and registered output stream
    always_ff @(posedge aclk) begin
        if (rst) begin
            cnt                  <= '0;
            len                  <= '0;
            sum                  <= '0;
            rd                   <= '0;
            exp_reg              <= '0;
            div_in_tvalid        <= 1'b0;
            div_in_tlast         <= 1'b0;
            dividend_power_tdata <= '0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (in_hs) begin
                        sum <= sum + {8'b0, exp_in_tdata};
                        cnt <= cnt + CW'(1);
                        if (load_done) len <= cnt + CW'(1);
                    end
                end
                ST_CALC: begin
                    // Exponent and first word go out together so valid rises right after CALC
                    exp_reg              <= exp_calc;
                    rd                   <= '0;
                    div_in_tvalid        <= 1'b1;
                    dividend_power_tdata <= buf_mem[0];
                    div_in_tlast         <= (len == CW'(1));
                end
                ST_SEND: begin
                    if (out_hs) begin
                        if (div_in_tlast) begin
                            div_in_tvalid <= 1'b0;
                            div_in_tlast  <= 1'b0;
                            cnt           <= '0;
                            sum           <= '0;
                            rd            <= '0;
                        end else begin
                            rd                   <= rd_nxt;
                            dividend_power_tdata <= buf_mem[rd_nxt];
                            div_in_tlast         <= (CW'(rd_nxt) == len - CW'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_div_feeder.sv
// tb_softmax_div_feeder: randomized and directed vectors against a
// transaction-level reference model of the exp-sum / replay behaviour.
module tb_softmax_div_feeder;
    localparam int VL = 10;
    localparam int SB = 12;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        exp_in_tvalid = 1'b0;
    logic        exp_in_tready;
    logic [23:0] exp_in_tdata = '0;
    logic        exp_in_tlast = 1'b0;
    logic        div_in_tvalid;
    logic        div_in_tready = 1'b1;
    logic [7:0]  divisor_exponent_tdata;
    logic [23:0] dividend_power_tdata;
    logic        div_in_tlast;

    softmax_div_feeder #(.VEC_LEN(VL), .SUM_BIAS(SB)) dut (
        .aclk                   (aclk),
        .rst                    (rst),
        .exp_in_tvalid          (exp_in_tvalid),
        .exp_in_tready          (exp_in_tready),
        .exp_in_tdata           (exp_in_tdata),
        .exp_in_tlast           (exp_in_tlast),
        .div_in_tvalid          (div_in_tvalid),
        .div_in_tready          (div_in_tready),
        .divisor_exponent_tdata (divisor_exponent_tdata),
        .dividend_power_tdata   (dividend_power_tdata),
        .div_in_tlast           (div_in_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [23:0] d;
        logic [7:0]  e;
        logic        l;
    } beat_t;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          mode     = 0;   // 0: ready high, 1: toggle, 2: random
    int          out_cnt  = 0;

    beat_t       exp_q[$];
    logic [23:0] part_q[$];
    logic [23:0] stim_d[$];
    logic        stim_l[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Downstream ready pattern
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (mode)
                0:       div_in_tready = 1'b1;
                1:       div_in_tready = ~div_in_tready;
                default: div_in_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model and output monitor, sampled on the falling edge
    logic        prev_rst   = 1'b0;
    logic        stall_prev = 1'b0;
    logic        calc_arm   = 1'b0;
    logic        valid_arm  = 1'b0;
    logic        rdy_arm    = 1'b0;
    logic [23:0] prev_d;
    logic [7:0]  prev_e;
    logic        prev_l;
    int unsigned m_sum;
    int unsigned m_t;
    int          m_k;
    logic [7:0]  m_e;
    beat_t       m_b;

    always @(negedge aclk) begin
        if (prev_rst) begin
            check("rst_tvalid", div_in_tvalid, 0);
            check("rst_tlast", div_in_tlast, 0);
            check("rst_exp", divisor_exponent_tdata, 0);
            check("rst_data", dividend_power_tdata, 0);
            check("rst_tready", exp_in_tready, 1);
        end
        if (rst) begin
            part_q.delete();
            exp_q.delete();
            calc_arm   = 1'b0;
            valid_arm  = 1'b0;
            rdy_arm    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", div_in_tvalid, 1);
                check("stall_data", dividend_power_tdata, prev_d);
                check("stall_exp", divisor_exponent_tdata, prev_e);
                check("stall_last", div_in_tlast, prev_l);
            end
            if (calc_arm) begin
                check("calc_tvalid", div_in_tvalid, 0);
                check("calc_tready", exp_in_tready, 0);
                calc_arm  = 1'b0;
                valid_arm = 1'b1;
            end else if (valid_arm) begin
                check("first_valid", div_in_tvalid, 1);
                valid_arm = 1'b0;
            end
            if (rdy_arm) begin
                check("ready_after_last", exp_in_tready, 1);
                rdy_arm = 1'b0;
            end
            if (div_in_tvalid) check("no_overlap", exp_in_tready, 0);

            if (exp_in_tvalid && exp_in_tready) begin
                part_q.push_back(exp_in_tdata);
                if (exp_in_tlast || part_q.size() == VL) begin
                    m_sum = 0;
                    foreach (part_q[j]) m_sum += part_q[j];
                    if (m_sum == 0) begin
                        m_e = 8'hF0;
                    end else begin
                        m_k = 0;
                        m_t = m_sum;
                        while (m_t > 1) begin
                            m_t = m_t / 2;
                            m_k++;
                        end
                        m_e = 8'(m_k - SB);
                    end
                    foreach (part_q[j]) begin
                        m_b.d = part_q[j];
                        m_b.e = m_e;
                        m_b.l = (j == part_q.size() - 1);
                        exp_q.push_back(m_b);
                    end
                    part_q.delete();
                    calc_arm = 1'b1;
                end
            end

            if (div_in_tvalid && div_in_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", exp_q.size(), 1);
                end else begin
                    m_b = exp_q.pop_front();
                    check("out_data", dividend_power_tdata, m_b.d);
                    check("out_exp", divisor_exponent_tdata, m_b.e);
                    check("out_last", div_in_tlast, m_b.l);
                end
                out_cnt++;
                if (div_in_tlast) rdy_arm = 1'b1;
            end

            stall_prev = div_in_tvalid && !div_in_tready;
            prev_d     = dividend_power_tdata;
            prev_e     = divisor_exponent_tdata;
            prev_l     = div_in_tlast;
        end
        prev_rst = rst;
    end

    // Offers one beat (called just after a rising edge); returns cycles spent not ready
    task automatic drive_beat(input logic [23:0] d, input logic l, output int waited);
        waited        = 0;
        exp_in_tvalid = 1'b1;
        exp_in_tdata  = d;
        exp_in_tlast  = l;
        @(negedge aclk);
        while (!exp_in_tready && waited < 5000) begin
            waited++;
            @(negedge aclk);
        end
        check("in_accept", exp_in_tready, 1);
        @(posedge aclk);
        #1;
    endtask

    // Drives stim_d/stim_l back to back; optionally checks the ready gap after each vector
    task automatic run_stream(input bit gap_chk);
        int cnt      = 0;
        int prev_len = 0;
        int waited;
        bit after_end = 1'b0;
        for (int i = 0; i < stim_d.size(); i++) begin
            drive_beat(stim_d[i], stim_l[i], waited);
            if (gap_chk && after_end) check("ready_gap", waited, prev_len + 1);
            cnt++;
            after_end = 1'b0;
            if (stim_l[i] || cnt == VL) begin
                after_end = 1'b1;
                prev_len  = cnt;
                cnt       = 0;
            end
        end
        exp_in_tvalid = 1'b0;
        exp_in_tlast  = 1'b0;
        stim_d.delete();
        stim_l.delete();
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || div_in_tvalid) && guard < 5000) begin
            @(posedge aclk);
            #1;
            guard++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic add_vec(input int n, input logic [23:0] d, input bit with_last);
        for (int j = 0; j < n; j++) begin
            stim_d.push_back(d);
            stim_l.push_back(with_last && (j == n - 1));
        end
    endtask

    task automatic add_rand_vec(input int n);
        int          w;
        logic [31:0] v;
        w = $urandom_range(0, 24);
        for (int j = 0; j < n; j++) begin
            v = (w == 0) ? 32'd0 : ($urandom & ((32'd1 << w) - 32'd1));
            stim_d.push_back(v[23:0]);
            stim_l.push_back(j == n - 1);
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int g;
        repeat (3) @(posedge aclk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // Basic 4-beat vector
        mode = 0;
        add_vec(4, 24'h000100, 1'b1);
        run_stream(1'b1);
        wait_drain();

        // Full vector without tlast, then an 11th beat that must wait for SEND to end
        add_vec(VL, 24'hFFFFFF, 1'b0);
        add_vec(1, 24'h000001, 1'b1);
        run_stream(1'b1);
        wait_drain();

        // All-zero vector
        add_vec(3, 24'h000000, 1'b1);
        run_stream(1'b1);
        wait_drain();

        // Backpressure with toggling ready
        mode = 1;
        for (int j = 1; j <= 5; j++) begin
            stim_d.push_back(24'(j));
            stim_l.push_back(j == 5);
        end
        run_stream(1'b0);
        wait_drain();
        mode = 0;
        repeat (2) @(posedge aclk);
        #1;

        // Reset after two of four beats have been sent
        base = out_cnt;
        add_vec(4, 24'h000050, 1'b1);
        run_stream(1'b0);
        g = 0;
        while (out_cnt < base + 2 && g < 200) begin
            @(posedge aclk);
            g++;
        end
        check("mid_send_progress", out_cnt - base, 2);
        #1;
        rst = 1'b1;
        @(posedge aclk);
        #1;
        rst = 1'b0;
        @(posedge aclk);
        #1;
        add_vec(2, 24'h000800, 1'b1);
        run_stream(1'b1);
        wait_drain();

        // Three back-to-back vectors with input valid held high
        add_rand_vec(3);
        add_rand_vec(7);
        add_rand_vec(VL);
        run_stream(1'b1);
        wait_drain();

        // Randomized vectors and ready patterns
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 2);
            repeat (2) @(posedge aclk);
            #1;
            for (int v = 0; v < int'($urandom_range(1, 3)); v++) begin
                add_rand_vec($urandom_range(1, VL + 1));
            end
            run_stream(mode == 0);
            wait_drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/softmax_div_feeder.md
# softmax_div_feeder

Buffers one softmax vector of exponential values and accumulates their sum. It converts the sum into a signed base-2 exponent, then replays every buffered value with that exponent as a handshaked stream. It is the sending side of the divide interface: it sits between the exp stage and `div_softmax` and drives `div_in_*`, `divisor_exponent_tdata` and `dividend_power_tdata`.

## Interface
- `VEC_LEN`, 10: maximum elements per vector; legal range 2..256.
- `SUM_BIAS`, 12: subtracted from the sum's MSB index to form the exponent.
- `aclk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `exp_in_tvalid` in 1: input beat valid.
- `exp_in_tready` out 1: input beat accepted when `exp_in_tvalid` and `exp_in_tready` are both 1.
- `exp_in_tdata` in 24: unsigned exponential value.
- `exp_in_tlast` in 1: last element of the vector.
- `div_in_tvalid` out 1: output beat valid.
- `div_in_tready` in 1: downstream accepts the beat.
- `divisor_exponent_tdata` out 8: signed exponent of the vector sum.
- `dividend_power_tdata` out 24: buffered exp value, in arrival order.
- `div_in_tlast` out 1: marks the final element of the vector.

## Operation
- The FSM has three states: LOAD, CALC and SEND. Reset enters LOAD.
- **LOAD**
  - `exp_in_tready`=1.
  - Each accepted beat is written to `buf[cnt]`, added to a 32-bit `sum`, and increments `cnt`.
  - The state exits to CALC on an accepted beat with `exp_in_tlast`=1, or on the beat that makes `cnt`==`VEC_LEN`, whichever comes first.
  - The vector length `len` is latched as the final `cnt`.
  - A beat arriving after `cnt` reaches `VEC_LEN` is not accepted; LOAD has already exited.
- **CALC** lasts exactly one cycle, with `exp_in_tready`=0.
  - `msb` = index of the highest set bit of `sum`.
  - `exp_reg` = `msb` − `SUM_BIAS` (signed 8-bit).
  - If `sum`==0, `exp_reg` = −16.
  - `rd` is set to 0.
- **SEND**
  - `exp_in_tready`=0.
  - Outputs are registered:
    - `div_in_tvalid`=1
    - `dividend_power_tdata`=`buf[rd]`
    - `divisor_exponent_tdata`=`exp_reg`
    - `div_in_tlast`=(`rd`==`len`−1)
  - On each handshake, `rd` increments and the next buffered word is presented in the following cycle, so there are no bubbles.
  - On the handshake with `div_in_tlast`=1, the FSM returns to LOAD and clears `cnt`, `sum` and `rd`.
- Width and arithmetic rules:
  - `sum` is 32 bits and cannot overflow (24 + 8 bits).
  - The exponent range is −12..+19, plus −16 for an all-zero vector.
  - `divisor_exponent_tdata` is constant across every beat of a vector.
- Synchronous `rst` at any state, including mid-SEND or mid-LOAD, forces the following:
  - state=LOAD; `cnt`, `sum`, `rd` and `exp_reg` cleared.
  - `div_in_tvalid`=0, `div_in_tlast`=0, data outputs 0.
  - Any partial vector is discarded.
  - Buffer contents are not cleared.

## Timing
- Reset values: `exp_in_tready`=1 (the cycle after `rst` deasserts), `div_in_tvalid`=0, `div_in_tlast`=0, `divisor_exponent_tdata`=0, `dividend_power_tdata`=0.
- If the last input beat is accepted in cycle T:
  - T+1 is CALC.
  - `div_in_tvalid` first goes high in T+2.
  - `exp_in_tready` is 0 from T+1 until the cycle after the last output handshake.
- If the final output handshake is in cycle S, `exp_in_tready`=1 in S+1.
- Output stall rule: while `div_in_tvalid`=1 and `div_in_tready`=0, all `div_in_*`, `divisor_exponent_tdata` and `dividend_power_tdata` hold stable.
- `div_in_tvalid` never drops without a handshake, except on `rst`.
- Throughput with `div_in_tready` held at 1: one beat per cycle out, so one vector per `len`+`len`+1 cycles.
- No input and output overlap: LOAD and SEND are exclusive.
- `exp_in_tvalid` is ignored outside LOAD.

## Test plan
- **Basic vector:** 4 beats of 0x000100, `exp_in_tlast` on the 4th, `div_in_tready`=1.
  - Required: 4 output beats of 0x000100 with exponent 0xFE (−2), `div_in_tlast` on beat 4.
  - Required: first valid 2 cycles after the last input.
- **Full vector, no tlast:** 10 beats of 0xFFFFFF, `exp_in_tlast` never asserted.
  - Sum is 0x9FFFFF6, so msb=27 and exponent=15 (0x0F).
  - Required: 10 outputs, `div_in_tlast` on the 10th; an 11th input offered is not accepted until SEND completes.
- **Edge sums:**
  - All-zero 3-beat vector → exponent 0xF0 (−16) on all 3 beats.
  - Single-beat vector 0x000001 with tlast → exponent 0xF4 (−12), `div_in_tlast` on that beat.
- **Backpressure:** 5-beat vector 1,2,3,4,5 with `div_in_tready` toggling 0,1,0,1…
  - Required: outputs 1..5 in order, no loss or duplication.
  - Required: data stable during every stall cycle.
- **Reset mid-SEND:** `rst` for 1 cycle after 2 of 4 beats have been sent.
  - Required: next cycle `div_in_tvalid`=0 and `exp_in_tready`=1.
  - A following vector of 2×0x000800 yields exponent 0 and 2 clean beats.
- **Back-to-back vectors:** 3 consecutive vectors with `exp_in_tvalid` held high.
  - Required: each vector's exponent computed only from its own elements.
  - Required: `exp_in_tready` gaps exactly as specified in Timing.
